shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_pkg.sv | 13 +
 rtl/shift_seq_shift_1.sv | 15 +
 rtl/shift_seq.sv | 50 +++++
 tb/tb_shift_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding, shift codes and widths for shift_seq
package shift_seq_pkg;
  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  localparam logic [1:0] FUN_SLL = 2'b00;
  localparam logic [1:0] FUN_SRL = 2'b01;
  localparam logic [1:0] FUN_SRA = 2'b11;
endpackage

// File: rtl/shift_seq_shift_1.sv
// shift_1: one-bit shift stage, passes the operand through when disabled
module shift_1
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        fun_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] y_o
);
  always_comb
    y_o = !en_i             ? b_i :
          fun_i == FUN_SLL ? {b_i[DATA_W-2:0], 1'b0} :
          fun_i == FUN_SRL ? {1'b0, b_i[DATA_W-1:1]} :
                             {b_i[DATA_W-1], b_i[DATA_W-1:1]};
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter applying one bit of shift per clock
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  B,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         ALUfun,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  y
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, shifted;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0] fun_q, fun_d;
  logic accept;
  shift_1 u_shift_1 (
    .b_i  (data_q),
    .fun_i(fun_q),
    .en_i (state_q == SHIFT),
    .y_o  (shifted)
  );
  always_comb begin
    accept  = start && state_q != SHIFT;
    state_d = accept            ? (shamt != '0 ? SHIFT : DONE) :
              state_q == SHIFT ? (cnt_q == SHAMT_W'(1) ? DONE : SHIFT) :
                                 IDLE;
    data_d  = accept ? B : shifted;
    cnt_d   = accept ? shamt : state_q == SHIFT ? cnt_q - SHAMT_W'(1) : cnt_q;
    fun_d   = accept ? ALUfun : fun_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fun_q   <= FUN_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fun_q   <= fun_d;
    end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign y    = data_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: randomized and directed checks of shift_seq against a timing/arithmetic model
module tb_shift_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] b = 0;
  logic [4:0] sh = 0;
  logic [1:0] fun = 0;
  logic busy, done;
  logic [31:0] y;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic act = 0;
  int acc = 0, msh = 0;
  logic [31:0] mb = 0;
  logic [1:0] mf = 0;
  logic done_seen = 0;
  int nbusy = 0, done_off = 0;

  shift_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .B(b), .shamt(sh),
    .ALUfun(fun), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] f, input int n);
    logic signed [31:0] t;
    if (f == 2'b00) return v << n;
    if (f == 2'b01) return v >> n;
    t = $signed(v) >>> n;
    return t;
  endfunction

  function automatic logic m_busy();
    return act && (cyc - acc) < msh;
  endfunction

  function automatic logic m_done();
    return act && (cyc - acc) == msh;
  endfunction

  function automatic logic [31:0] m_y();
    int e;
    e = cyc - acc;
    if (e > msh) e = msh;
    return act ? ref_shift(mb, mf, e) : 32'h0;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, a, e);
    end
  endtask

  task automatic check();
    cmp("busy", 32'(busy), 32'(m_busy()));
    cmp("done", 32'(done), 32'(m_done()));
    cmp("y", y, m_y());
  endtask

  task automatic step(input logic s, input logic [31:0] bv, input logic [4:0] shv, input logic [1:0] fv);
    logic acc_now;
    start = s; b = bv; sh = shv; fun = fv;
    @(posedge clk);
    acc_now = s && !m_busy();
    cyc++;
    if (acc_now) begin
      act = 1; acc = cyc; mb = bv; msh = shv; mf = fv;
    end
    #1;
    check();
    if (busy) nbusy++;
    if (done) begin
      done_seen = 1;
      done_off = cyc - acc;
    end
  endtask

  task automatic idle();
    step(0, $urandom, 5'($urandom), 2'($urandom));
  endtask

  task automatic start_op(input logic [31:0] bv, input logic [4:0] shv, input logic [1:0] fv);
    done_seen = 0; nbusy = 0; done_off = -1;
    step(1, bv, shv, fv);
  endtask

  task automatic run_until_done();
    for (int i = 0; i < 40 && !done_seen; i++) idle();
    cmp("done_timeout", 32'(done_seen), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    act = 0;
    #2;
    check();
    @(posedge clk);
    cyc++;
    #1;
    check();
    rst_n = 1;
  endtask

  initial begin
    #3;
    check();
    @(posedge clk);
    cyc++;
    #1;
    check();
    rst_n = 1;
    start_op(32'h1, 5'd4, 2'b00);
    run_until_done();
    cmp("sll4_y", y, 32'h10);
    cmp("sll4_busy_cycles", 32'(nbusy), 32'd4);
    cmp("sll4_latency", 32'(done_off), 32'd4);
    idle();
    start_op(32'h80000000, 5'd31, 2'b11);
    run_until_done();
    cmp("sra31_y", y, 32'hFFFFFFFF);
    cmp("sra31_latency", 32'(done_off), 32'd31);
    start_op(32'h80000000, 5'd31, 2'b01);
    run_until_done();
    cmp("srl31_y", y, 32'h00000001);
    cmp("srl31_latency", 32'(done_off), 32'd31);
    start_op(32'h80000000, 5'd3, 2'b10);
    run_until_done();
    cmp("sra10_y", y, 32'hF0000000);
    start_op(32'hDEADBEEF, 5'd0, 2'b01);
    cmp("sh0_done_now", 32'(done), 32'd1);
    cmp("sh0_y", y, 32'hDEADBEEF);
    idle();
    cmp("sh0_busy_cycles", 32'(nbusy), 32'd0);
    start_op(32'h0000FFFF, 5'd8, 2'b00);
    idle();
    step(1, 32'h1, 5'd3, 2'b01);
    run_until_done();
    cmp("ignored_start_y", y, 32'h00FFFF00);
    cmp("ignored_start_latency", 32'(done_off), 32'd8);
    idle();
    start_op(32'hABCD1234, 5'd20, 2'b00);
    repeat (4) idle();
    do_reset();
    cmp("reset_y", y, 32'h0);
    cmp("reset_busy", 32'(busy), 32'd0);
    done_seen = 0;
    repeat (25) idle();
    cmp("reset_no_done", 32'(done_seen), 32'd0);
    start_op(32'h2, 5'd1, 2'b01);
    run_until_done();
    cmp("post_reset_y", y, 32'h1);
    start_op(32'hF0, 5'd2, 2'b01);
    run_until_done();
    cmp("b2b_first_y", y, 32'h3C);
    start_op(32'h12345678, 5'd4, 2'b00);
    cmp("b2b_no_idle_busy", 32'(busy), 32'd1);
    run_until_done();
    cmp("b2b_second_y", y, 32'h23456780);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, $urandom,
                $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                2'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
